// File: rtl/sync_fifo_ctl_if.sv
// Handshake/status bundle between a FIFO user (master) and sync_fifo_ctl (slave).
// With FIFO_PARITY_EN defined, the bundle also carries the parity error pulse and its sticky copy.
interface sync_fifo_ctl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 9
);
    logic              clr;
    logic              wr_en;
    logic [WIDTH-1:0]  din;
    logic              rd_en;
    logic [WIDTH-1:0]  dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   usedw;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_PARITY_EN
    logic              parity_err;
    logic              parity_sticky;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               usedw, overflow, underflow, parity_err, parity_sticky
    );
    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               usedw, overflow, underflow, parity_err, parity_sticky
    );
`else
    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               usedw, overflow, underflow
    );
    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               usedw, overflow, underflow
    );
`endif
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with power-of-two depth, normal or show-ahead read, thresholds and sticky errors.
// Optional macro FIFO_PARITY_EN stores an even-parity bit per entry and flags mismatches on read.
module sync_fifo_ctl #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 9,
    parameter int SHOWAHEAD = 0,
    parameter int AF_LEVEL  = 2**ADDR_W - 4,
    parameter int AE_LEVEL  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_ctl_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef FIFO_PARITY_EN
    localparam int MEM_W = WIDTH + 1;
`else
    localparam int MEM_W = WIDTH;
`endif
    localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THR = (ADDR_W+1)'(AE_LEVEL);

    logic [MEM_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, wr_ok, rd_ok;
    logic [ADDR_W:0]  usedw;
    logic [MEM_W-1:0] wr_word, head_word;

    // Extra wrap bit makes full and empty distinguishable when the low bits match.
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign usedw = wr_ptr_q - rd_ptr_q;

    // A flush wins over any request in the same cycle.
    assign wr_ok = bus.wr_en && !full  && !bus.clr;
    assign rd_ok = bus.rd_en && !empty && !bus.clr;

`ifdef FIFO_PARITY_EN
    assign wr_word = {^bus.din, bus.din};
`else
    assign wr_word = bus.din;
`endif
    assign head_word = mem[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_word;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
            // A write while full is dropped even if a read frees a slot this cycle.
            if (bus.wr_en && full)  overflow_d  = 1'b1;
            if (bus.rd_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.usedw        = usedw;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.almost_full  = (usedw >= AF_THR);
    assign bus.almost_empty = (usedw <= AE_THR);

    generate
        if (SHOWAHEAD != 0) begin : g_fwft
            assign bus.dout       = head_word[WIDTH-1:0];
            assign bus.dout_valid = !empty;
`ifdef FIFO_PARITY_EN
            assign bus.parity_err = !empty && (^head_word);
`endif
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q, dout_d;
            logic             dout_valid_q, dout_valid_d;
`ifdef FIFO_PARITY_EN
            logic             parity_err_q, parity_err_d;
`endif

            always_comb begin
                dout_d       = rd_ok ? head_word[WIDTH-1:0] : dout_q;
                dout_valid_d = rd_ok;
`ifdef FIFO_PARITY_EN
                parity_err_d = rd_ok && (^head_word);
`endif
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
`ifdef FIFO_PARITY_EN
                    parity_err_q <= 1'b0;
`endif
                end else begin
                    dout_q       <= dout_d;
                    dout_valid_q <= dout_valid_d;
`ifdef FIFO_PARITY_EN
                    parity_err_q <= parity_err_d;
`endif
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = dout_valid_q;
`ifdef FIFO_PARITY_EN
            assign bus.parity_err = parity_err_q;
`endif
        end
    endgenerate

`ifdef FIFO_PARITY_EN
    logic parity_sticky_q, parity_sticky_d;

    always_comb begin
        parity_sticky_d = parity_sticky_q;
        if (bus.clr) begin
            parity_sticky_d = 1'b0;
        end else if (bus.parity_err) begin
            parity_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_sticky_q <= 1'b0;
        end else begin
            parity_sticky_q <= parity_sticky_d;
        end
    end

    assign bus.parity_sticky = parity_sticky_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives a registered-read and a show-ahead FIFO with identical traffic and checks both
// against a queue-based reference model.
module tb_sync_fifo_ctl;
    localparam int W     = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_ctl_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
    sync_fifo_ctl_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

    sync_fifo_ctl #(.WIDTH(W), .ADDR_W(AW), .SHOWAHEAD(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sync_fifo_ctl #(.WIDTH(W), .ADDR_W(AW), .SHOWAHEAD(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus sticky flags and the registered-read output.
    logic [W-1:0] q[$];
    logic         m_ovf, m_udf, m_dv;
    logic [W-1:0] m_dout;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dv   = 1'b0;
        m_dout = '0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("usedw0", 64'(bus0.usedw), 64'(n));
        chk("full0", 64'(bus0.full), 64'(n == DEPTH));
        chk("empty0", 64'(bus0.empty), 64'(n == 0));
        chk("afull0", 64'(bus0.almost_full), 64'(n >= AF));
        chk("aempty0", 64'(bus0.almost_empty), 64'(n <= AE));
        chk("ovf0", 64'(bus0.overflow), 64'(m_ovf));
        chk("udf0", 64'(bus0.underflow), 64'(m_udf));
        chk("dvalid0", 64'(bus0.dout_valid), 64'(m_dv));
        chk("dout0", 64'(bus0.dout), 64'(m_dout));
        chk("usedw1", 64'(bus1.usedw), 64'(n));
        chk("full1", 64'(bus1.full), 64'(n == DEPTH));
        chk("empty1", 64'(bus1.empty), 64'(n == 0));
        chk("afull1", 64'(bus1.almost_full), 64'(n >= AF));
        chk("aempty1", 64'(bus1.almost_empty), 64'(n <= AE));
        chk("ovf1", 64'(bus1.overflow), 64'(m_ovf));
        chk("udf1", 64'(bus1.underflow), 64'(m_udf));
        chk("dvalid1", 64'(bus1.dout_valid), 64'(n != 0));
        if (n != 0) chk("dout1", 64'(bus1.dout), 64'(q[0]));
    endtask

    task automatic drive(input logic c, input logic w, input logic [W-1:0] d, input logic r);
        bus0.clr = c; bus0.wr_en = w; bus0.din = d; bus0.rd_en = r;
        bus1.clr = c; bus1.wr_en = w; bus1.din = d; bus1.rd_en = r;
    endtask

    // One clock of traffic: apply inputs, update the model at the edge, check at the falling edge.
    task automatic cycle(input logic c, input logic w, input logic [W-1:0] d, input logic r);
        bit was_full, was_empty;
        drive(c, w, d, r);
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv  = 1'b0;
        end else begin
            m_dv = 1'b0;
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) begin
                m_dout = q.pop_front();
                m_dv   = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
        end
        @(negedge clk);
        $display("t=%0t clr=%0b wr=%0b din=%02h rd=%0b | usedw=%0d dout0=%02h dv0=%0b dout1=%02h dv1=%0b ovf=%0b udf=%0b",
                 $time, c, w, d, r, bus0.usedw, bus0.dout, bus0.dout_valid,
                 bus1.dout, bus1.dout_valid, bus0.overflow, bus0.underflow);
        check_all();
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ordering and one-cycle read latency
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, W'(i), 1'b0);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, '0, 1'b1);

        // Fill to full, then writes while full (with and without a read); drain past empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, W'($urandom_range(0, 8'h7F)), 1'b0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Flush at usedw=5 with overflow still set and a write in the same cycle
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'h55, 1'b0);

        // Show-ahead visibility of a single word, then pop
        cycle(1'b0, 1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Steady state at 4 words with simultaneous read/write across pointer wraps
        for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b1);

        // Asynchronous reset in the middle of a cycle
        drive(1'b0, 1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Random traffic with drifting write/read bias so the fill level sweeps its range
        for (int i = 0; i < 400; i++) begin
            int wb, rb;
            wb = ((i / 50) % 2 == 0) ? 70 : 30;
            rb = 100 - wb;
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 99) < wb),
                  W'($urandom),
                  ($urandom_range(0, 99) < rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
